uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial receive front end of the UART. Placed between the rx pad and the RX FIFO / register block.
- Synchronises the rx line and generates 16x oversampling ticks from the programmed divider.
- Detects start bits and deserialises LSB-first data words, with optional parity.
- Delivers each word on a valid/ready interface together with the per-frame parity_error, framing_error and overrun_error flags that feed the RX interrupt flags.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, ticks per bit; must be even.
- DIV_W, 16, width of the divider input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- divider_i  in  DIV_W  tick period minus 1, in clk cycles (DIVIDER register)
- parity_en_i  in  1  a parity bit follows the data bits
- parity_odd_i  in  1  1 = odd parity, 0 = even parity
- flush_i  in  1  discard the held output word
- rx_i  in  1  asynchronous serial input, idle high
- data_o  out  DATA_BITS  received word
- valid_o  out  1  data_o holds an unconsumed word
- ready_i  in  1  consumer accepts the word (valid_o & ready_i = transfer)
- parity_error_o  out  1  held word had a parity mismatch
- framing_error_o  out  1  held word had stop bit = 0
- overrun_error_o  out  1  one-cycle pulse: a completed frame was dropped
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM = IDLE; tick counter = 0; synchroniser flops = 1.
- Synchroniser: rx_i passes through 2 flops (rx_s). A third flop (rx_q) is used for edge detection. Total input latency is 2 cycles.
- Tick generator:
  - tick_cnt counts 0..divider_i and pulses tick when tick_cnt == divider_i, then wraps to 0.
  - divider_i = 0 gives a tick every cycle.
  - Free-running; a divider_i change takes effect at the next wrap.
- Sample counter (scnt, range 0..OVERSAMPLE-1) advances only on tick.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_q=1 and rx_s=0 (falling edge), go to START with scnt=0. A line held low (break) never retriggers; it needs a high before the next edge.
  - START: at the tick where scnt == OVERSAMPLE/2-1 (mid-bit), sample rx_s.
    - rx_s = 1: glitch; return to IDLE with no output.
    - rx_s = 0: go to DATA with scnt=0 and bit index = 0.
  - DATA: at each tick where scnt == OVERSAMPLE-1, shift rx_s into bit[index], LSB first. After DATA_BITS samples, go to PARITY if parity_en_i, else go to STOP.
  - PARITY: sample at scnt == OVERSAMPLE-1. perr = (XOR of data bits XOR sampled bit) != parity_odd_i. Then go to STOP.
  - STOP: sample at scnt == OVERSAMPLE-1. ferr = (rx_s == 0). The frame is complete; go to IDLE in the same cycle, so a start edge in the second half of the stop bit is detected.
- parity_en_i and parity_odd_i are sampled at the START→DATA transition and held for the frame.
- Frame completion (registered, visible the cycle after the stop sample):
  - If valid_o=0, or valid_o=1 and ready_i=1 in the completion cycle: load data_o, parity_error_o=perr, framing_error_o=ferr, and set valid_o=1.
  - Else: the new word is dropped, the held word and its flags are unchanged, and overrun_error_o pulses for 1 cycle.
  - Framing-error words are still delivered, with the flag set.
- Handshake: valid_o & ready_i clears valid_o, parity_error_o and framing_error_o the next cycle, unless a completion reloads them in the same cycle.
- flush_i: clears valid_o, parity_error_o and framing_error_o next cycle.
  - A frame in progress continues.
  - flush_i coincident with completion: the new word is loaded (flush loses to the load); no overrun.
- rst mid-frame: immediate return to reset values; the partial frame is discarded.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
- divider_i=0, 8N1, send 0xA5 (bit period 16 clk) → valid_o rises about 2+8+9*16 cycles after the start edge; data_o=0xA5, both errors 0; ready_i=1 clears valid_o next cycle.
- parity_en=1, parity_odd=0, send 0x03 with parity bit 1 → parity_error_o=1, data_o=0x03; repeat with parity bit 0 → parity_error_o=0.
- Stop bit driven 0 for 0x55 → framing_error_o=1, data_o=0x55; then a line-low break of 30 bit times → exactly one frame (0x00, framing error), no retrigger until rx returns high.
- Low glitch of 4 clk on rx at divider_i=0 → FSM returns to IDLE at START mid-bit; valid_o stays 0.
- ready_i=0, send 0x11 then 0x22 → data_o stays 0x11, overrun_error_o pulses once at the second completion; repeat with ready_i=1 in the completion cycle → 0x22 loaded, no overrun.
- divider_i=3, back-to-back frames 0x00, 0xFF with a start edge immediately after the stop sample → both received; assert rst mid-frame → all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with start-bit glitch rejection,
// optional parity, and a single-word valid/ready output holding per-frame error flags.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     divider_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 flush_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_error_o,
    output logic                 framing_error_o,
    output logic                 overrun_error_o,
    output logic                 busy_o
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_d;
    logic                 rx_m, rx_s, rx_q;
    logic [DIV_W-1:0]     tick_cnt, div_q;
    logic [SW-1:0]        scnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q, par_odd_q, perr;
    logic                 tick, mid, full, done, fill;

    // div_q only reloads on a wrap, so a divider write never truncates a tick period
    assign tick   = tick_cnt == div_q;
    assign mid    = tick && scnt == SW'(OVERSAMPLE / 2 - 1);
    assign full   = tick && scnt == SW'(OVERSAMPLE - 1);
    assign done   = state == STOP && full;
    assign fill   = !valid_o || ready_i || flush_i;
    assign busy_o = state != IDLE;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = (rx_q && !rx_s) ? START : IDLE;
            START:   state_d = mid ? (rx_s ? IDLE : DATA) : START;
            DATA:    state_d = (full && bit_idx == BW'(DATA_BITS - 1)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_d = full ? STOP : PARITY;
            STOP:    state_d = full ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {rx_q, rx_s, rx_m} <= 3'b111;
            tick_cnt           <= '0;
            div_q              <= '0;
            scnt               <= '0;
            bit_idx            <= '0;
            shreg              <= '0;
            par_en_q           <= 1'b0;
            par_odd_q          <= 1'b0;
            perr               <= 1'b0;
            data_o             <= '0;
            valid_o            <= 1'b0;
            parity_error_o     <= 1'b0;
            framing_error_o    <= 1'b0;
            overrun_error_o    <= 1'b0;
        end else begin
            {rx_q, rx_s, rx_m} <= {rx_s, rx_m, rx_i};
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) div_q <= divider_i;
            scnt <= (state_d != state) ? '0 :
                    tick ? ((scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + 1'b1) : scnt;
            if (state == START && state_d == DATA) begin
                bit_idx   <= '0;
                par_en_q  <= parity_en_i;
                par_odd_q <= parity_odd_i;
                perr      <= 1'b0;
            end
            if (state == DATA && full) begin
                shreg[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 1'b1;
            end
            if (state == PARITY && full) perr <= (^shreg ^ rx_s) != par_odd_q;
            // a completing frame wins over flush and over a same-cycle handshake
            overrun_error_o <= done && !fill;
            if (done && fill) begin
                data_o          <= shreg;
                parity_error_o  <= perr;
                framing_error_o <= !rx_s;
                valid_o         <= 1'b1;
            end else if (flush_i || (valid_o && ready_i)) begin
                valid_o         <= 1'b0;
                parity_error_o  <= 1'b0;
                framing_error_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames with an expected-word queue drained by a handshake monitor.
module tb_uart_rx_core;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] divider = '0;
    logic        parity_en = 1'b0, parity_odd = 1'b0, flush = 1'b0, rx = 1'b1, ready = 1'b1;
    logic [7:0]  data;
    logic        valid, pe, fe, ovr, busy;
    logic [9:0]  exp_q[$];
    int          n_chk = 0, n_fail = 0, n_ovr = 0, bp = 16;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .divider_i(divider), .parity_en_i(parity_en),
        .parity_odd_i(parity_odd), .flush_i(flush), .rx_i(rx), .data_o(data),
        .valid_o(valid), .ready_i(ready), .parity_error_o(pe), .framing_error_o(fe),
        .overrun_error_o(ovr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic pen, input logic pbit,
                        input logic stop, input int stop_cyc);
        rx = 1'b0;
        idle(bp);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(bp);
        end
        if (pen) begin
            rx = pbit;
            idle(bp);
        end
        rx = stop;
        idle(stop_cyc);
        rx = 1'b1;
    endtask

    // inputs change on negedge, so valid&ready seen here is what the next posedge samples
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (ovr) n_ovr++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL word: got %0h with no word expected", {data, pe, fe});
                end else check("word {data,pe,fe}", 32'({data, pe, fe}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle(4);
        check("rst valid", 32'(valid), 0);
        check("rst data", 32'(data), 0);
        check("rst perr", 32'(pe), 0);
        check("rst ferr", 32'(fe), 0);
        check("rst ovr", 32'(ovr), 0);
        check("rst busy", 32'(busy), 0);
        rst = 1'b0;
        idle(10);

        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        fork
            send(8'hA5, 1'b0, 1'b0, 1'b1, bp);
            begin
                int cnt = 0;
                logic seen = 1'b0;
                while (!seen && cnt < 400) begin
                    @(posedge clk);
                    #1;
                    cnt++;
                    if (cnt == 20) check("busy mid-frame", 32'(busy), 1);
                    seen = valid;
                end
                check("latency", 32'(cnt), 155);
                @(posedge clk);
                #1;
                check("valid cleared", 32'(valid), 0);
            end
        join
        idle(bp);

        parity_en = 1'b1;
        parity_odd = 1'b0;
        exp_q.push_back({8'h03, 1'b1, 1'b0});
        send(8'h03, 1'b1, 1'b1, 1'b1, bp);
        idle(bp);
        exp_q.push_back({8'h03, 1'b0, 1'b0});
        send(8'h03, 1'b1, 1'b0, 1'b1, bp);
        idle(bp);
        parity_odd = 1'b1;
        exp_q.push_back({8'h03, 1'b0, 1'b0});
        send(8'h03, 1'b1, 1'b1, 1'b1, bp);
        idle(bp);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        exp_q.push_back({8'h55, 1'b0, 1'b1});
        send(8'h55, 1'b0, 1'b0, 1'b0, bp);
        idle(bp);
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        rx = 1'b0;
        idle(30 * bp);
        check("break busy", 32'(busy), 0);
        rx = 1'b1;
        idle(2 * bp);
        check("break one frame", 32'(exp_q.size()), 0);
        check("break idle", 32'(busy), 0);

        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(1);
        #1;
        check("glitch busy", 32'(busy), 1);
        idle(20);
        check("glitch idle", 32'(busy), 0);
        check("glitch no word", 32'(valid), 0);

        ready = 1'b0;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        send(8'h11, 1'b0, 1'b0, 1'b1, bp);
        idle(bp);
        send(8'h22, 1'b0, 1'b0, 1'b1, bp);
        idle(4);
        check("overrun pulses", 32'(n_ovr), 1);
        check("overrun held data", 32'(data), 32'h11);
        check("overrun held valid", 32'(valid), 1);
        ready = 1'b1;
        idle(bp);

        ready = 1'b0;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        exp_q.push_back({8'h22, 1'b0, 1'b0});
        send(8'h11, 1'b0, 1'b0, 1'b1, bp);
        idle(bp);
        fork
            send(8'h22, 1'b0, 1'b0, 1'b1, bp);
            begin
                idle(154);
                ready = 1'b1;
            end
        join
        idle(bp);
        check("reload no overrun", 32'(n_ovr), 1);
        check("reload drained", 32'(exp_q.size()), 0);

        ready = 1'b0;
        send(8'h77, 1'b0, 1'b0, 1'b1, bp);
        idle(4);
        check("flush pre valid", 32'(valid), 1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        #1;
        check("flush valid", 32'(valid), 0);
        ready = 1'b1;
        idle(bp);

        divider = 16'd3;
        bp = 64;
        idle(20);
        exp_q.push_back({8'h00, 1'b0, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        send(8'h00, 1'b0, 1'b0, 1'b1, 48);
        send(8'hFF, 1'b0, 1'b0, 1'b1, bp);
        idle(bp);
        check("back-to-back drained", 32'(exp_q.size()), 0);

        ready = 1'b0;
        send(8'hC3, 1'b0, 1'b0, 1'b1, bp);
        idle(8);
        check("pre-rst valid", 32'(valid), 1);
        rx = 1'b0;
        idle(3 * bp);
        rst = 1'b1;
        idle(2);
        rx = 1'b1;
        #1;
        check("mid rst valid", 32'(valid), 0);
        check("mid rst data", 32'(data), 0);
        check("mid rst busy", 32'(busy), 0);
        check("mid rst flags", 32'({pe, fe, ovr}), 0);
        rst = 1'b0;
        ready = 1'b1;
        idle(bp);
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        send(8'h5A, 1'b0, 1'b0, 1'b1, bp);
        idle(2 * bp);

        check("queue empty", 32'(exp_q.size()), 0);
        check("total overruns", 32'(n_ovr), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
